// File: rtl/mpc_types.sv
// Shared types for the MPC issue path: channel one-hot ids, cache op encodings
// and the width configuration record.
package mpc_types;

    localparam logic [2:0] CH_0_1HOT = 3'b001;
    localparam logic [2:0] CH_1_1HOT = 3'b010;
    localparam logic [2:0] CH_2_1HOT = 3'b100;

    typedef enum logic [2:0] {
        CACHE_OP_RD    = 3'd0,
        CACHE_OP_RDS   = 3'd1,
        CACHE_OP_RDX   = 3'd2,
        CACHE_OP_WR    = 3'd3,
        CACHE_OP_WAE   = 3'd4,
        CACHE_OP_INV   = 3'd5,
        CACHE_OP_FLUSH = 3'd6,
        CACHE_OP_NOP   = 3'd7
    } cache_op_e;

    typedef struct packed {
        int robWidth;
        int nlineWidth;
        int offsetWidth;
        int wbufWidth;
    } mpc_cfg_t;

    localparam mpc_cfg_t MPC_CFG_DEFAULT = '{
        robWidth:    4,
        nlineWidth:  5,
        offsetWidth: 1,
        wbufWidth:   7
    };

endpackage

// File: rtl/isu_rr_pick.sv
// Combinational 3-way round-robin picker: the first eligible channel at or
// after ptr (wrapping) receives the one-hot grant.
module isu_rr_pick (
    input  logic [2:0] eligible,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 3; k++) begin
            idx = 2'((int'(ptr) + k) % 3);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/isu_chn_arb.sv
// Three-channel credit-gated round-robin issue arbiter feeding isu_wrapper.
// Optional macro ISU_ARB_CRDT_ERR_EN adds a sticky credit-overflow flag crdt_err.
module isu_chn_arb
    import mpc_types::*;
#(
    parameter mpc_cfg_t CFG      = MPC_CFG_DEFAULT,
    parameter int       CH_NUM   = 3,
    parameter int       ROB_SIZE = 16,
    parameter int       ROB_W    = CFG.robWidth,
    parameter int       CRDT_W   = $clog2(ROB_SIZE + 1),
    parameter int       NLINE_W  = CFG.nlineWidth,
    parameter int       OFFSET_W = CFG.offsetWidth,
    parameter int       WBUF_W   = CFG.wbufWidth
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CH_NUM-1:0]                  req_valid,
    output logic [CH_NUM-1:0]                  req_ready,
    input  logic [CH_NUM-1:0][2:0]             req_op,
    input  logic [CH_NUM-1:0][NLINE_W-1:0]     req_id,
    input  logic [CH_NUM-1:0][OFFSET_W-1:0]    req_offset,
    input  logic [CH_NUM-1:0][WBUF_W-1:0]      req_wbuf_id,
    input  logic [CH_NUM-1:0][CRDT_W-1:0]      crdt_rtn,
    output logic                               d_valid,
    input  logic                               d_ready,
    output logic [2:0]                         d_channel_1hot_id,
    output logic [ROB_W-1:0]                   d_rob_id,
    output logic [2:0]                         d_op,
    output logic [NLINE_W-1:0]                 d_id,
    output logic [OFFSET_W-1:0]                d_offset,
    output logic [WBUF_W-1:0]                  d_wbuf_id,
    output logic [CH_NUM-1:0][CRDT_W-1:0]      crdt_avail
`ifdef ISU_ARB_CRDT_ERR_EN
    ,
    output logic                               crdt_err
`endif
);

    logic [CH_NUM-1:0][CRDT_W-1:0] crdt;
    logic [CH_NUM-1:0][CRDT_W-1:0] crdt_nxt;
    logic [CH_NUM-1:0][CRDT_W:0]   crdt_sum;
    logic [CH_NUM-1:0][ROB_W-1:0]  robptr;
    logic [1:0]                    ptr;
    logic [CH_NUM-1:0]             eligible;
    logic [CH_NUM-1:0]             grant;
    logic                          can_load;

    logic [2:0]          sel_op;
    logic [NLINE_W-1:0]  sel_id;
    logic [OFFSET_W-1:0] sel_offset;
    logic [WBUF_W-1:0]   sel_wbuf_id;
    logic [ROB_W-1:0]    sel_rob;

    function automatic logic [CRDT_W-1:0] sat_crdt(input logic [CRDT_W:0] v);
        if (v > (CRDT_W+1)'(ROB_SIZE)) begin
            return CRDT_W'(ROB_SIZE);
        end
        return v[CRDT_W-1:0];
    endfunction

    function automatic logic [ROB_W-1:0] rob_inc(input logic [ROB_W-1:0] r);
        if (r == ROB_W'(ROB_SIZE - 1)) begin
            return '0;
        end
        return r + 1'b1;
    endfunction

    function automatic logic [1:0] next_ptr(input logic [2:0] g);
        case (g)
            CH_0_1HOT: return 2'd1;
            CH_1_1HOT: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

    // Eligibility depends only on registered credits, never on this cycle's returns.
    assign can_load = !d_valid || d_ready;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            eligible[i] = req_valid[i] && (crdt[i] != '0) && can_load;
        end
    end

    isu_rr_pick u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant)
    );

    assign req_ready  = grant;
    assign crdt_avail = crdt;

    always_comb begin
        sel_op      = '0;
        sel_id      = '0;
        sel_offset  = '0;
        sel_wbuf_id = '0;
        sel_rob     = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (grant[i]) begin
                sel_op      = req_op[i];
                sel_id      = req_id[i];
                sel_offset  = req_offset[i];
                sel_wbuf_id = req_wbuf_id[i];
                sel_rob     = robptr[i];
            end
        end
    end

    // Net credit update; a same-cycle grant and return combine before saturation.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            crdt_sum[i] = {1'b0, crdt[i]} - {{CRDT_W{1'b0}}, grant[i]} + {1'b0, crdt_rtn[i]};
            crdt_nxt[i] = sat_crdt(crdt_sum[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 2'd0;
            robptr <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                crdt[i] <= CRDT_W'(ROB_SIZE);
            end
        end else begin
            crdt <= crdt_nxt;
            if (|grant) begin
                ptr <= next_ptr(grant);
            end
            for (int i = 0; i < CH_NUM; i++) begin
                if (grant[i]) begin
                    robptr[i] <= rob_inc(robptr[i]);
                end
            end
        end
    end

    // Output stage: loads on grant, otherwise holds payload until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid           <= 1'b0;
            d_channel_1hot_id <= '0;
            d_rob_id          <= '0;
            d_op              <= '0;
            d_id              <= '0;
            d_offset          <= '0;
            d_wbuf_id         <= '0;
        end else if (|grant) begin
            d_valid           <= 1'b1;
            d_channel_1hot_id <= grant;
            d_rob_id          <= sel_rob;
            d_op              <= sel_op;
            d_id              <= sel_id;
            d_offset          <= sel_offset;
            d_wbuf_id         <= sel_wbuf_id;
        end else if (d_ready) begin
            d_valid <= 1'b0;
        end
    end

`ifdef ISU_ARB_CRDT_ERR_EN
    logic [CH_NUM-1:0] crdt_ovf;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            crdt_ovf[i] = crdt_sum[i] > (CRDT_W+1)'(ROB_SIZE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crdt_err <= 1'b0;
        end else if (|crdt_ovf) begin
            crdt_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_isu_chn_arb.sv
// Randomized bench for isu_chn_arb against a queue-free behavioural model of
// credits, round-robin priority and the single-entry output stage.
module tb_isu_chn_arb;
    import mpc_types::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0][2:0]  req_op;
    logic [2:0][4:0]  req_id;
    logic [2:0][0:0]  req_offset;
    logic [2:0][6:0]  req_wbuf_id;
    logic [2:0][4:0]  crdt_rtn;
    logic             d_valid;
    logic             d_ready;
    logic [2:0]       d_channel_1hot_id;
    logic [3:0]       d_rob_id;
    logic [2:0]       d_op;
    logic [4:0]       d_id;
    logic [0:0]       d_offset;
    logic [6:0]       d_wbuf_id;
    logic [2:0][4:0]  crdt_avail;
`ifdef ISU_ARB_CRDT_ERR_EN
    logic             crdt_err;
`endif

    always #5 clk = ~clk;

    isu_chn_arb dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_id            (req_id),
        .req_offset        (req_offset),
        .req_wbuf_id       (req_wbuf_id),
        .crdt_rtn          (crdt_rtn),
        .d_valid           (d_valid),
        .d_ready           (d_ready),
        .d_channel_1hot_id (d_channel_1hot_id),
        .d_rob_id          (d_rob_id),
        .d_op              (d_op),
        .d_id              (d_id),
        .d_offset          (d_offset),
        .d_wbuf_id         (d_wbuf_id),
        .crdt_avail        (crdt_avail)
`ifdef ISU_ARB_CRDT_ERR_EN
        ,
        .crdt_err          (crdt_err)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int         m_crdt [3];
    int         m_rob  [3];
    int         m_ptr;
    bit         m_dv;
    logic [2:0] m_ch;
    int         m_robid;
    logic [2:0] m_op;
    logic [4:0] m_id;
    logic [0:0] m_off;
    logic [6:0] m_wbuf;
    bit         m_err;
    int         m_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_crdt[i] = 16;
            m_rob[i]  = 0;
        end
        m_ptr = 0; m_dv = 0; m_ch = '0; m_robid = 0;
        m_op = '0; m_id = '0; m_off = '0; m_wbuf = '0; m_err = 0;
    endtask

    function automatic int model_pick();
        if (m_dv && !d_ready) return -1;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (m_ptr + k) % 3;
            if (req_valid[c] && m_crdt[c] > 0) return c;
        end
        return -1;
    endfunction

    task automatic model_update();
        if (m_g >= 0) begin
            m_dv    = 1;
            m_ch    = 3'b001 << m_g;
            m_robid = m_rob[m_g];
            m_op    = req_op[m_g];
            m_id    = req_id[m_g];
            m_off   = req_offset[m_g];
            m_wbuf  = req_wbuf_id[m_g];
            m_rob[m_g] = (m_rob[m_g] + 1) % 16;
            m_ptr   = (m_g + 1) % 3;
        end else if (d_ready) begin
            m_dv = 0;
        end
        for (int i = 0; i < 3; i++) begin
            int s;
            s = m_crdt[i] - ((m_g == i) ? 1 : 0) + int'(crdt_rtn[i]);
            if (s > 16) begin
                m_err = 1;
                s = 16;
            end
            m_crdt[i] = s;
        end
    endtask

    task automatic check_outputs();
        chk("d_valid", d_valid, m_dv);
        chk("d_channel_1hot_id", d_channel_1hot_id, m_ch);
        chk("d_rob_id", d_rob_id, m_robid);
        chk("d_op", d_op, m_op);
        chk("d_id", d_id, m_id);
        chk("d_offset", d_offset, m_off);
        chk("d_wbuf_id", d_wbuf_id, m_wbuf);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("crdt_avail%0d", i), crdt_avail[i], m_crdt[i]);
        end
`ifdef ISU_ARB_CRDT_ERR_EN
        chk("crdt_err", crdt_err, m_err);
`endif
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        #1;
        m_g = model_pick();
        chk("req_ready", req_ready, (m_g >= 0) ? (3'b001 << m_g) : 3'b000);
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        req_valid = '0; req_op = '0; req_id = '0; req_offset = '0;
        req_wbuf_id = '0; crdt_rtn = '0; d_ready = 1'b1;
    endtask

    task automatic rand_payload();
        req_op      = 9'($urandom);
        req_id      = 15'($urandom);
        req_offset  = 3'($urandom);
        req_wbuf_id = 21'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_outputs();
        chk("rst_req_ready", req_ready, 3'b000);
    endtask

    initial begin
        logic [2:0] bp_ch;
        logic [3:0] bp_rob;
        logic [2:0] bp_op;
        logic [4:0] bp_id;

        set_idle();
        do_reset();
        for (int i = 0; i < 3; i++) chk("rst_crdt", crdt_avail[i], 16);

        // Single request on channel 1
        req_valid = 3'b010;
        req_op[1] = CACHE_OP_WAE;
        req_id[1] = {2'd3, 3'd5};
        req_wbuf_id[1] = 7'd7;
        step();
        chk("single_ch", d_channel_1hot_id, 3'b010);
        chk("single_rob", d_rob_id, 0);
        chk("single_op", d_op, CACHE_OP_WAE);
        chk("single_crdt1", crdt_avail[1], 15);
        set_idle();
        step();

        // Round-robin with all channels requesting
        do_reset();
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            rand_payload();
            step();
            chk("rr_ch", d_channel_1hot_id, 3'b001 << (k % 3));
            chk("rr_rob", d_rob_id, k / 3);
        end
        set_idle();
        step();

        // Credit exhaustion on channel 0 and ROB id wrap
        do_reset();
        req_valid = 3'b001;
        repeat (16) begin
            rand_payload();
            step();
        end
        step();
        chk("exh_ready", req_ready, 3'b000);
        chk("exh_crdt0", crdt_avail[0], 0);
        crdt_rtn[0] = 5'd1;
        step();
        crdt_rtn[0] = 5'd0;
        step();
        chk("wrap_ch", d_channel_1hot_id, 3'b001);
        chk("wrap_rob", d_rob_id, 0);

        // Backpressure: output held, no grants
        req_valid = 3'b111;
        rand_payload();
        step();
        bp_ch = d_channel_1hot_id; bp_rob = d_rob_id; bp_op = d_op; bp_id = d_id;
        d_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_payload();
            crdt_rtn[0] = 5'($urandom_range(0, 1));
            step();
            chk("bp_ready", req_ready, 3'b000);
            chk("bp_valid", d_valid, 1);
            chk("bp_ch", d_channel_1hot_id, bp_ch);
            chk("bp_rob", d_rob_id, bp_rob);
            chk("bp_op", d_op, bp_op);
            chk("bp_id", d_id, bp_id);
        end
        set_idle();
        step();

        // Simultaneous grant and return on channel 2
        do_reset();
        req_valid = 3'b100;
        repeat (6) step();
        chk("sim_pre_crdt2", crdt_avail[2], 10);
        crdt_rtn[2] = 5'd2;
        step();
        chk("sim_crdt2", crdt_avail[2], 11);
        set_idle();
        step();

`ifdef ISU_ARB_CRDT_ERR_EN
        do_reset();
        crdt_rtn[0] = 5'd3;
        step();
        chk("sat_crdt0", crdt_avail[0], 16);
        chk("sat_err", crdt_err, 1);
        set_idle();
        step();
        chk("sat_err_sticky", crdt_err, 1);
`endif

        // Randomized traffic with a mid-run reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            req_valid = 3'($urandom);
            rand_payload();
            d_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                int r;
                r = $urandom_range(0, 9);
                crdt_rtn[i] = (r < 7) ? 5'd0 : 5'(r - 6);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
